// File: rtl/board_manager.sv
// board_manager: playfield storage with lock, line-clear and game-over handling.
// Ports:
//   frame_clk, Reset             clock, asynchronous active-high reset
//   lock_valid / lock_ready      lock handshake; lock_x1..4, lock_y1..4, lock_color = piece cells
//   query_x/y -> query_occupied  collision probe (outside the board counts as occupied)
//   draw_x/y  -> draw_color      renderer read port (0 = empty or out of range)
//   lines_cleared, clear_pulse, game_over  status
module board_manager #(
    parameter int BOARD_W = 12,
    parameter int BOARD_H = 19
) (
    input  logic        frame_clk,
    input  logic        Reset,
    input  logic        lock_valid,
    output logic        lock_ready,
    input  logic [5:0]  lock_x1,
    input  logic [5:0]  lock_x2,
    input  logic [5:0]  lock_x3,
    input  logic [5:0]  lock_x4,
    input  logic [6:0]  lock_y1,
    input  logic [6:0]  lock_y2,
    input  logic [6:0]  lock_y3,
    input  logic [6:0]  lock_y4,
    input  logic [3:0]  lock_color,
    input  logic [5:0]  query_x,
    input  logic [6:0]  query_y,
    output logic        query_occupied,
    input  logic [5:0]  draw_x,
    input  logic [6:0]  draw_y,
    output logic [3:0]  draw_color,
    output logic [15:0] lines_cleared,
    output logic        clear_pulse,
    output logic        game_over
);
    typedef enum logic [2:0] {IDLE, WRITE, SCAN, SHIFT, DONE} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cells_q [BOARD_H][BOARD_W];
    logic [5:0]  px_q [4];
    logic [6:0]  py_q [4];
    logic [3:0]  color_q;
    logic [6:0]  row_q;
    logic [2:0]  cnt_q;
    logic [15:0] lines_q;
    logic        over_q;
    logic        row_full, row0_any;
    logic [3:0]  q_cell, d_cell, wr_color;

    // A zero colour would make the locked cells look empty, so force a visible one.
    assign wr_color = (color_q == 4'h0) ? 4'hF : color_q;

    always_comb begin
        row_full = 1'b0;
        row0_any = 1'b0;
        q_cell   = '0;
        d_cell   = '0;
        for (int y = 0; y < BOARD_H; y++) begin
            if (row_q == 7'(y)) begin
                row_full = 1'b1;
                for (int x = 0; x < BOARD_W; x++) row_full = row_full & (cells_q[y][x] != 4'h0);
            end
            for (int x = 0; x < BOARD_W; x++) begin
                if (query_y == 7'(y) && query_x == 6'(x)) q_cell = cells_q[y][x];
                if (draw_y == 7'(y) && draw_x == 6'(x)) d_cell = cells_q[y][x];
            end
        end
        for (int x = 0; x < BOARD_W; x++) row0_any = row0_any | (cells_q[0][x] != 4'h0);
    end

    assign query_occupied = (query_x >= 6'(BOARD_W)) || (query_y >= 7'(BOARD_H)) || (q_cell != 4'h0);
    assign draw_color     = d_cell;

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (lock_valid && lock_ready) ? WRITE : IDLE;
            WRITE:   state_d = SCAN;
            SCAN:    state_d = row_full ? SHIFT : ((row_q == 7'd0) ? DONE : SCAN);
            SHIFT:   state_d = SCAN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        lock_ready    = (state_q == IDLE) && !over_q;
        clear_pulse   = (state_q == DONE) && (cnt_q != 3'd0);
        game_over     = over_q;
        lines_cleared = lines_q;
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            for (int y = 0; y < BOARD_H; y++)
                for (int x = 0; x < BOARD_W; x++) cells_q[y][x] <= 4'h0;
            px_q    <= '{default: '0};
            py_q    <= '{default: '0};
            color_q <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            lines_q <= '0;
            over_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (lock_valid && lock_ready) begin
                    px_q    <= '{lock_x1, lock_x2, lock_x3, lock_x4};
                    py_q    <= '{lock_y1, lock_y2, lock_y3, lock_y4};
                    color_q <= lock_color;
                end
                WRITE: begin
                    // Out-of-range coordinates match no cell and are dropped; duplicates collapse.
                    for (int y = 0; y < BOARD_H; y++)
                        for (int x = 0; x < BOARD_W; x++)
                            for (int i = 0; i < 4; i++)
                                if (px_q[i] == 6'(x) && py_q[i] == 7'(y)) cells_q[y][x] <= wr_color;
                    row_q <= 7'(BOARD_H - 1);
                    cnt_q <= '0;
                end
                SCAN: if (!row_full && row_q != 7'd0) row_q <= row_q - 7'd1;
                SHIFT: begin
                    // Everything above the full row drops by one; row_q stays so the new row is rescanned.
                    for (int y = 1; y < BOARD_H; y++)
                        if (7'(y) <= row_q) cells_q[y] <= cells_q[y-1];
                    cells_q[0] <= '{default: '0};
                    lines_q    <= (lines_q == 16'hFFFF) ? lines_q : lines_q + 16'd1;
                    cnt_q      <= cnt_q + 3'd1;
                end
                DONE: if (row0_any) over_q <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_board_manager.sv
// tb_board_manager: directed and randomized checks of board_manager against a row-list model.
module tb_board_manager;
    localparam int W = 12;
    localparam int H = 19;

    logic        frame_clk = 1'b0;
    logic        Reset = 1'b1;
    logic        lock_valid = 1'b0;
    logic        lock_ready;
    logic [5:0]  lx [4] = '{default: '0};
    logic [6:0]  ly [4] = '{default: '0};
    logic [3:0]  lock_color = '0;
    logic [5:0]  query_x = '0;
    logic [6:0]  query_y = '0;
    logic        query_occupied;
    logic [5:0]  draw_x = '0;
    logic [6:0]  draw_y = '0;
    logic [3:0]  draw_color;
    logic [15:0] lines_cleared;
    logic        clear_pulse;
    logic        game_over;

    int tests = 0;
    int fails = 0;
    int mb [H][W];
    int m_lines;
    bit m_over;

    board_manager #(.BOARD_W(W), .BOARD_H(H)) dut (
        .frame_clk(frame_clk), .Reset(Reset),
        .lock_valid(lock_valid), .lock_ready(lock_ready),
        .lock_x1(lx[0]), .lock_x2(lx[1]), .lock_x3(lx[2]), .lock_x4(lx[3]),
        .lock_y1(ly[0]), .lock_y2(ly[1]), .lock_y3(ly[2]), .lock_y4(ly[3]),
        .lock_color(lock_color),
        .query_x(query_x), .query_y(query_y), .query_occupied(query_occupied),
        .draw_x(draw_x), .draw_y(draw_y), .draw_color(draw_color),
        .lines_cleared(lines_cleared), .clear_pulse(clear_pulse), .game_over(game_over)
    );

    always #5 frame_clk = ~frame_clk;

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        foreach (mb[y, x]) mb[y][x] = 0;
        m_lines = 0;
        m_over  = 0;
    endfunction

    // Place the piece, then rebuild the board from the non-full rows stacked at the bottom.
    function automatic int model_lock(input int xs[4], input int ys[4], input int c);
        int keep[$];
        int nb [H][W];
        int cl;
        bit full;
        for (int i = 0; i < 4; i++)
            if (xs[i] < W && ys[i] < H) mb[ys[i]][xs[i]] = (c == 0) ? 15 : c;
        for (int y = H - 1; y >= 0; y--) begin
            full = 1;
            for (int x = 0; x < W; x++) if (mb[y][x] == 0) full = 0;
            if (!full) keep.push_back(y);
        end
        foreach (nb[y, x]) nb[y][x] = 0;
        for (int k = 0; k < keep.size(); k++)
            for (int x = 0; x < W; x++) nb[H-1-k][x] = mb[keep[k]][x];
        mb = nb;
        cl = H - keep.size();
        m_lines = (m_lines + cl > 65535) ? 65535 : m_lines + cl;
        for (int x = 0; x < W; x++) if (mb[0][x] != 0) m_over = 1;
        return cl;
    endfunction

    task automatic check_board(input string tag);
        chk({tag, " lines_cleared"}, lines_cleared, m_lines);
        chk({tag, " game_over"}, game_over, m_over);
        chk({tag, " lock_ready"}, lock_ready, !m_over);
        chk({tag, " clear_pulse idle"}, clear_pulse, 0);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                draw_x = 6'(x); draw_y = 7'(y); query_x = 6'(x); query_y = 7'(y);
                #1;
                chk($sformatf("%s draw(%0d,%0d)", tag, x, y), draw_color, mb[y][x]);
                chk($sformatf("%s query(%0d,%0d)", tag, x, y), query_occupied, mb[y][x] != 0);
            end
    endtask

    task automatic probe(input int x, input int y, input int occ, input int col);
        query_x = 6'(x); query_y = 7'(y); draw_x = 6'(x); draw_y = 7'(y);
        #1;
        chk($sformatf("probe occ(%0d,%0d)", x, y), query_occupied, occ);
        chk($sformatf("probe col(%0d,%0d)", x, y), draw_color, col);
    endtask

    task automatic do_reset();
        @(negedge frame_clk);
        Reset = 1'b1;
        @(negedge frame_clk);
        Reset = 1'b0;
        model_reset();
        check_board("reset");
    endtask

    task automatic do_lock(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input int x3, input int y3, input int c);
        int xs[4];
        int ys[4];
        int n, pulses, cl;
        bit acc;
        xs = '{x0, x1, x2, x3};
        ys = '{y0, y1, y2, y3};
        @(negedge frame_clk);
        for (int i = 0; i < 4; i++) begin
            lx[i] = 6'(xs[i]);
            ly[i] = 7'(ys[i]);
        end
        lock_color = 4'(c);
        lock_valid = 1'b1;
        chk("lock_ready before lock", lock_ready, !m_over);
        acc = !m_over;
        @(negedge frame_clk);
        lock_valid = 1'b0;
        cl = acc ? model_lock(xs, ys, c) : 0;
        n = 1;
        pulses = 0;
        while (!(lock_ready || game_over) && n < 80) begin
            pulses += int'(clear_pulse);
            @(negedge frame_clk);
            n++;
        end
        if (acc) chk("lock latency", n, 22 + 2 * cl);
        chk("clear_pulse count", pulses, (cl > 0) ? 1 : 0);
        check_board("after lock");
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge frame_clk);
        Reset = 1'b0;
        check_board("power-on");

        // 2x2 square at bottom-left, no clear
        do_lock(0, 18, 1, 18, 0, 17, 1, 17, 3);
        probe(1, 17, 1, 3);
        probe(2, 18, 0, 0);

        // single line clear, row 17 drops into row 18, colour 0 becomes F
        do_reset();
        do_lock(0, 18, 1, 18, 2, 18, 3, 18, 2);
        do_lock(4, 18, 5, 18, 6, 18, 7, 18, 4);
        do_lock(0, 17, 1, 17, 2, 17, 5, 17, 7);
        do_lock(8, 18, 9, 18, 10, 18, 11, 18, 0);
        probe(5, 18, 1, 7);
        probe(0, 0, 0, 0);

        // four-line clear by a vertical I piece; duplicate coordinates in the filler locks
        do_reset();
        for (int y = 15; y <= 18; y++) begin
            do_lock(1, y, 2, y, 3, y, 4, y, 1);
            do_lock(5, y, 6, y, 7, y, 8, y, 2);
            do_lock(9, y, 10, y, 11, y, 11, y, 9);
        end
        do_lock(0, 15, 0, 16, 0, 17, 0, 18, 12);

        // out-of-range probes and a partly out-of-range lock
        do_reset();
        probe(12, 0, 1, 0);
        probe(0, 19, 1, 0);
        probe(63, 127, 1, 0);
        do_lock(10, 18, 11, 18, 12, 18, 9, 18, 5);
        probe(11, 18, 1, 5);
        probe(12, 18, 1, 0);

        // Reset asserted while the board is shifting
        do_reset();
        do_lock(0, 18, 1, 18, 2, 18, 3, 18, 6);
        do_lock(4, 18, 5, 18, 6, 18, 7, 18, 6);
        draw_x = 6'd0; draw_y = 7'd18;
        @(negedge frame_clk);
        lx = '{6'd8, 6'd9, 6'd10, 6'd11};
        ly = '{7'd18, 7'd18, 7'd18, 7'd18};
        lock_color = 4'd1;
        lock_valid = 1'b1;
        @(negedge frame_clk);
        lock_valid = 1'b0;
        @(negedge frame_clk);
        @(negedge frame_clk);
        chk("pre-reset cell (0,18)", draw_color, 6);
        Reset = 1'b1;
        #1;
        chk("async reset cell (0,18)", draw_color, 0);
        chk("async reset lines", lines_cleared, 0);
        @(negedge frame_clk);
        Reset = 1'b0;
        model_reset();
        check_board("reset in shift");
        do_lock(3, 18, 4, 18, 3, 17, 4, 17, 8);

        // game over: further locks ignored until Reset
        do_reset();
        do_lock(0, 0, 1, 0, 0, 1, 1, 1, 6);
        chk("game over set", game_over, 1);
        do_lock(5, 18, 6, 18, 7, 18, 8, 18, 2);
        do_lock(0, 18, 1, 18, 2, 18, 3, 18, 4);
        do_reset();

        // randomized locks, biased toward completing bottom rows
        for (int k = 0; k < 40; k++) begin
            int y, x0;
            if ($urandom_range(1) == 1) begin
                y  = $urandom_range(14, 18);
                x0 = 4 * $urandom_range(0, 2);
                do_lock(x0, y, x0 + 1, y, x0 + 2, y, x0 + 3, y, $urandom_range(0, 15));
            end else begin
                do_lock($urandom_range(0, 13), $urandom_range(4, 19), $urandom_range(0, 13), $urandom_range(4, 19),
                        $urandom_range(0, 13), $urandom_range(4, 19), $urandom_range(0, 13), $urandom_range(4, 19),
                        $urandom_range(0, 15));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/board_manager.md
BOARD_MANAGER -- requirements
Module: board_manager

Interface
REQ-001 SHALL have parameter BOARD_W, default 12: playfield columns, x = 0..BOARD_W-1.
REQ-002 SHALL have parameter BOARD_H, default 19: playfield rows, y = 0..BOARD_H-1, row 0 at top.
REQ-003 SHALL have port frame_clk, input, 1: clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port lock_valid, input, 1: lock request from piece logic.
REQ-006 SHALL have port lock_ready, output, 1: block can accept a lock.
REQ-007 SHALL have ports lock_x1..lock_x4, input, 6 each: column of each piece cell.
REQ-008 SHALL have ports lock_y1..lock_y4, input, 7 each: row of each piece cell.
REQ-009 SHALL have port lock_color, input, 4: palette index of the locked piece.
REQ-010 SHALL have ports query_x (input, 6) and query_y (input, 7): collision probe address.
REQ-011 SHALL have port query_occupied, output, 1: probed cell filled or outside the board.
REQ-012 SHALL have ports draw_x (input, 6) and draw_y (input, 7): renderer read address.
REQ-013 SHALL have port draw_color, output, 4: palette index at the draw address; 0 means empty.
REQ-014 SHALL have port lines_cleared, output, 16: running total of cleared rows.
REQ-015 SHALL have port clear_pulse, output, 1: one-cycle flag, lock cleared at least one row.
REQ-016 SHALL have port game_over, output, 1: sticky flag, row 0 occupied after a lock.

Function
REQ-017 SHALL store BOARD_W x BOARD_H cells of 4 bits each; a cell is occupied iff its value is nonzero.
REQ-018 SHALL drive query_occupied combinationally: 1 if query_x >= BOARD_W or query_y >= BOARD_H, else (cell != 0).
REQ-019 SHALL drive draw_color combinationally: cell value in range, 0 out of range.
REQ-020 SHALL implement FSM states IDLE, WRITE, SCAN, SHIFT, DONE; lock_ready = 1 only in IDLE with game_over = 0.
REQ-021 SHALL, in IDLE, on lock_valid && lock_ready, capture all lock_x*, lock_y* and lock_color and go to WRITE.
REQ-022 SHALL ignore lock_valid while lock_ready = 0; no capture and no state change.
REQ-023 SHALL, in WRITE, write the captured colour to all four cells in one cycle.
REQ-024 SHALL, in WRITE, substitute 4'hF when the captured colour is 0, so locked cells are always occupied.
REQ-025 SHALL, in WRITE, skip any cell with x >= BOARD_W or y >= BOARD_H and write the others.
REQ-026 SHALL, in WRITE, set scan row r = BOARD_H-1, clear the per-lock row counter, and go to SCAN.
REQ-027 SHALL, in SCAN, evaluate one row per cycle.
REQ-028 SHALL, in SCAN, go to SHIFT if all cells of row r are occupied.
REQ-029 SHALL, in SCAN, go to DONE if row r is not full and r = 0.
REQ-030 SHALL, in SCAN, decrement r and stay in SCAN if row r is not full and r > 0.
REQ-031 SHALL, in SHIFT, copy row k-1 into row k for every k = 1..r, and clear row 0 to zero, in one cycle.
REQ-032 SHALL, in SHIFT, increment lines_cleared, saturating at 16'hFFFF, and increment the per-lock counter.
REQ-033 SHALL, in SHIFT, return to SCAN with r unchanged, so the row moved down is rescanned.
REQ-034 SHALL, in DONE, assert clear_pulse for exactly this cycle iff the per-lock counter is nonzero.
REQ-035 SHALL, in DONE, set game_over if any cell of row 0 is occupied, then go to IDLE.
REQ-036 SHALL keep game_over set until Reset; while set, lock_ready stays 0.
REQ-037 SHALL make the board contents visible on the query and draw ports in the cycle after each write or shift.
REQ-038 SHALL handle duplicate coordinates within one lock as a single write to that cell.
REQ-039 SHALL handle worst-case latency as 1 (WRITE) + BOARD_H + 4 (SHIFT) + 4 (rescans) + 1 (DONE) cycles for a 4-line clear.

Reset
REQ-040 SHALL, on Reset, immediately and from any state, clear all cells and go to IDLE.
REQ-041 SHALL, on Reset, set lines_cleared = 0, clear_pulse = 0, game_over = 0, and lock_ready = 1 once Reset deasserts.
REQ-042 SHALL discard any captured lock on Reset mid-operation; no partial write survives.

Verification
REQ-043 SHALL cover: lock at (0,18),(1,18),(0,17),(1,17), colour 3 -> draw_color at (1,17) = 3, query at (2,18) = 0, clear_pulse never 1, lines_cleared = 0.
REQ-044 SHALL cover: row 18 pre-filled in columns 0..7, then lock x = 8..11, y = 18 -> clear_pulse once, lines_cleared = 1, row 18 = old row 17, row 0 = 0.
REQ-045 SHALL cover: rows 15..18 full except column 0, then vertical I piece at x = 0, y = 15..18 -> lines_cleared += 4, whole board empty, clear_pulse one cycle.
REQ-046 SHALL cover: query_x = 12 or query_y = 19 -> query_occupied = 1 and draw_color = 0; lock containing x = 12 writes only its three in-range cells.
REQ-047 SHALL cover: lock at y = 0 with no full row -> game_over = 1, lock_ready stays 0, later lock_valid pulses ignored, and Reset clears everything.
REQ-048 SHALL cover: Reset asserted during SHIFT -> board zero, FSM IDLE, lines_cleared = 0, and the next lock is accepted normally.
